// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage RV32I pipeline, between EX/MEM and MEM_WB.
// It launches each load or store as one req/ack transaction on the
// data-memory bus. It formats store byte lanes and sign/zero-extends load
// data. It holds the pipeline stalled until the access completes.
//
// Optional build macro:
//   MEM_MISALIGN_TRAP_EN  - when defined, a misaligned access is not sent to
//                           the bus. Instead it raises misalign_out for one
//                           cycle. When undefined, the offending low address
//                           bits are cleared and the access goes ahead.
//
// Ports:
//   clock, reset        rising-edge clock; synchronous active-high reset
//   valid_in            EX/MEM holds a live instruction
//   mem_read_in         load request
//   mem_write_in        store request
//   funct3_in           access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr_in             byte address (ALU result)
//   store_data_in       rs2 value for stores
//   dmem_req            registered bus request
//   dmem_we             1 = write
//   dmem_addr           word-aligned bus address
//   dmem_wdata          lane-replicated store data
//   dmem_wstrb          byte enables (0000 on reads)
//   dmem_rdata          read word, valid with dmem_ack
//   dmem_ack            completes the transaction at the sampling edge
//   read_data_out       extended load data, held until the next load completes
//   stall_out           freezes the upstream pipeline; MEM_WB not written
//   misalign_out        one-cycle pulse for a trapped misaligned access
//   state_dbg_out       current FSM state (0 IDLE, 1 REQ, 2 DONE)
//
// Bus handshake: dmem_req stays high, with addr/we/wdata/wstrb held constant,
// from the first REQ cycle until a rising edge at which dmem_ack=1 is
// sampled. That edge completes the transaction. dmem_rdata is only looked at
// on that edge. Reset may drop dmem_req without an ack.
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [2:0]        funct3_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       store_data_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic [31:0]       read_data_out,
    output logic              stall_out,
    output logic              misalign_out,
    output logic [1:0]        state_dbg_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              sign_q, sign_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              misalign_q, misalign_d;

    logic       mem_op;
    logic       trap;
    logic       launch;
    logic [1:0] size_in;
    logic [1:0] eff_off;
    logic [3:0] wstrb_fmt;
    logic [31:0] wdata_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign mem_op = valid_in & (mem_read_in | mem_write_in);

    // Size decode. The illegal encodings 011, 110 and 111 are treated as word.
    always_comb begin
        size_in = SZ_W;
        case (funct3_in[1:0])
            2'b00:   size_in = SZ_B;
            2'b01:   size_in = SZ_H;
            default: size_in = SZ_W;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = ((size_in == SZ_H) & addr_in[0]) |
                  ((size_in == SZ_W) & (addr_in[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // The lane offset always has the misaligned low bits cleared. Trapped
    // accesses never reach the bus, so this only matters in the non-trap
    // build, where it is what forces the access to the aligned lanes.
    always_comb begin
        eff_off = 2'b00;
        case (size_in)
            SZ_B:    eff_off = addr_in[1:0];
            SZ_H:    eff_off = {addr_in[1], 1'b0};
            default: eff_off = 2'b00;
        endcase
    end

    // Store lane formatting
    always_comb begin
        wstrb_fmt = 4'b1111;
        wdata_fmt = store_data_in;
        case (size_in)
            SZ_B: begin
                wstrb_fmt = 4'b0001 << eff_off;
                wdata_fmt = {4{store_data_in[7:0]}};
            end
            SZ_H: begin
                wstrb_fmt = 4'b0011 << eff_off;
                wdata_fmt = {2{store_data_in[15:0]}};
            end
            default: begin
                wstrb_fmt = 4'b1111;
                wdata_fmt = store_data_in;
            end
        endcase
    end

    // Load lane select and extension, using the attributes latched at launch
    always_comb begin
        ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
        ld_half = dmem_rdata[{off_q[1], 4'b0000} +: 16];
        ld_ext  = dmem_rdata;
        case (size_q)
            SZ_B:    ld_ext = {{24{sign_q & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_ext = {{16{sign_q & ld_half[15]}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    assign launch = (state_q == ST_IDLE) & mem_op & ~trap;

    // A trapped op only raises the pulse. It never stalls.
    assign misalign_d = (state_q == ST_IDLE) & mem_op & trap;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        size_d  = size_q;
        off_d   = off_q;
        sign_d  = sign_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    we_d    = mem_write_in;
                    addr_d  = {addr_in[ADDR_W-1:2], 2'b00};
                    wdata_d = wdata_fmt;
                    wstrb_d = mem_write_in ? wstrb_fmt : 4'b0000;
                    size_d  = size_in;
                    off_d   = eff_off;
                    sign_d  = ~funct3_in[2];
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = ld_ext;
                end
            end
            ST_DONE: begin
                // EX/MEM still holds the finished op during this cycle, so
                // return to IDLE without looking at mem_op.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            size_q     <= SZ_W;
            off_q      <= 2'b00;
            sign_q     <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            size_q     <= size_d;
            off_q      <= off_d;
            sign_q     <= sign_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign dmem_wstrb    = wstrb_q;
    assign read_data_out = rdata_q;
    assign stall_out     = launch | (state_q == ST_REQ);
    assign misalign_out  = misalign_q;
    assign state_dbg_out = state_q;

endmodule
